// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus arbitration interface.
// Bundles the per-core request/release strobes and the arbiter's grant outputs.
//   req           : per-core bus request (level)
//   release_pulse : per-core one-cycle end-of-transaction strobe
//   grant         : one-hot grant
//   grant_valid   : OR of grant
//   grant_id      : index of current owner, 0 when idle
//   timeout       : one-cycle pulse on forced revoke
//   hold_count    : cycles the current owner has held the bus
// Modports: master = cache-controller side, slave = arbiter side.
interface snoop_bus_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_HOLD  = 15
);
  localparam int unsigned ID_W = $clog2(NUM_CORES);
  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] release_pulse;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout;
  logic [HC_W-1:0]      hold_count;

  modport master (
    output req, release_pulse,
    input  grant, grant_valid, grant_id, timeout, hold_count
  );

  modport slave (
    input  req, release_pulse,
    output grant, grant_valid, grant_id, timeout, hold_count
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner arbiter for the shared snoop/coherence bus.
// One controller owns the bus until it strobes release or the hold watchdog
// revokes it; a one-cycle turnaround separates consecutive owners.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : snoop_bus_arbiter_if slave modport (req/release in, grant/status out)
module snoop_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_HOLD  = 15,
  parameter int unsigned ID_W      = $clog2(NUM_CORES)
) (
  input logic                clock,
  input logic                reset,
  snoop_bus_arbiter_if.slave bus
);
  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [HC_W-1:0]      hold_q, hold_d;
  logic                 timeout_q, timeout_d;

  logic                 found;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      cand;

  // Scan starting just after the last winner so the previous owner is lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = ID_W'((32'(last_q) + k) % NUM_CORES);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StBusy: begin
        // Release has priority over the watchdog in the same cycle.
        if (bus.release_pulse[id_q]) begin
          state_d = StTurn;
          grant_d = '0;
          id_d    = '0;
          hold_d  = '0;
        end else if (hold_q == HC_W'(MAX_HOLD)) begin
          state_d   = StTurn;
          grant_d   = '0;
          id_d      = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        // Idle and turnaround arbitrate identically.
        state_d = StIdle;
        grant_d = '0;
        id_d    = '0;
        hold_d  = '0;
        if (found) begin
          state_d         = StBusy;
          grant_d[winner] = 1'b1;
          id_d            = winner;
          last_d          = winner;
          hold_d          = HC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_CORES - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = id_q;
  assign bus.timeout     = timeout_q;
  assign bus.hold_count  = hold_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;
  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned MAX_HOLD  = 15;
  localparam int unsigned HC_W      = $clog2(MAX_HOLD + 1);
  localparam int          BOUND     = NUM_CORES * (MAX_HOLD + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  snoop_bus_arbiter_if #(.NUM_CORES(NUM_CORES), .MAX_HOLD(MAX_HOLD)) bus ();

  snoop_bus_arbiter #(.NUM_CORES(NUM_CORES), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit is_to;
    int id;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rand_mode = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_grant(input int id, input int c);
    sb.push_back('{1'b0, id, c});
  endtask

  task automatic expect_to(input int c);
    sb.push_back('{1'b1, 0, c});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.release_pulse = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_grant", bus.grant, 0);
    check("rst_valid", bus.grant_valid, 0);
    check("rst_id", bus.grant_id, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_hold", bus.hold_count, 0);
    step();
  endtask

  // Monitor: invariants every cycle, scoreboard events in directed mode.
  logic [NUM_CORES-1:0] prev_grant = '0;
  logic                 prev_valid = 1'b0;
  logic [HC_W-1:0]      prev_hold = '0;
  int                   wait_c[NUM_CORES];

  always @(negedge clock) begin
    int   exp_id;
    bit   new_grant;
    exp_t e;
    exp_id = 0;
    for (int i = 0; i < NUM_CORES; i++) if (bus.grant[i]) exp_id = i;
    check("onehot0", 32'($onehot0(bus.grant)), 1);
    check("valid_or", bus.grant_valid, 32'(|bus.grant));
    check("grant_id", bus.grant_id, exp_id);
    check("timeout_vs_valid", 32'(bus.timeout && bus.grant_valid), 0);
    if (bus.timeout) check("timeout_cause", 32'(prev_valid && prev_hold == HC_W'(MAX_HOLD)), 1);
    if (bus.grant_valid && prev_valid) check("turnaround", bus.grant, prev_grant);

    new_grant = bus.grant_valid && !(prev_valid && bus.grant == prev_grant);
    if (!rand_mode && (new_grant || bus.timeout)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_event: got kind=%0d id=%0d cyc=%0d required no event",
                 bus.timeout, exp_id, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_kind", 32'(bus.timeout), 32'(e.is_to));
        check("sb_id", bus.timeout ? 0 : exp_id, e.id);
        check("sb_cycle", cyc, e.cyc);
      end
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (!rand_mode) begin
        wait_c[i] = 0;
      end else if (bus.req[i] && !bus.grant[i]) begin
        wait_c[i]++;
        if (wait_c[i] == BOUND + 1) begin
          n_cmp++;
          n_err++;
          $display("FAIL starvation: core %0d waited %0d required <= %0d", i, wait_c[i], BOUND);
        end
      end else begin
        if (bus.grant[i] && wait_c[i] > 0) check("starve_wait", 32'(wait_c[i] <= BOUND), 1);
        wait_c[i] = 0;
      end
    end

    prev_grant = bus.grant;
    prev_valid = bus.grant_valid;
    prev_hold  = bus.hold_count;
  end

  initial begin
    int c;
    logic [NUM_CORES-1:0] r;
    bus.req = '0;
    bus.release_pulse = '0;

    // 1: single requester, hold counter, release
    do_reset();
    c = cyc;
    expect_grant(2, c + 1);
    bus.req = 4'b0100;
    step();
    check("t1_grant", bus.grant, 4'b0100);
    check("t1_hold1", bus.hold_count, 1);
    step();
    check("t1_hold2", bus.hold_count, 2);
    step();
    check("t1_hold3", bus.hold_count, 3);
    bus.release_pulse = 4'b0100;
    bus.req = '0;
    step();
    bus.release_pulse = '0;
    check("t1_released", bus.grant, 0);
    step();

    // 2: all request, each owner releases on its 3rd held cycle
    do_reset();
    c = cyc;
    for (int k = 0; k < 5; k++) expect_grant(k % 4, c + 1 + 4 * k);
    bus.req = 4'b1111;
    for (int i = 0; i < 19; i++) begin
      bus.release_pulse = '0;
      if (bus.grant_valid && bus.hold_count == 3) bus.release_pulse[bus.grant_id] = 1'b1;
      step();
    end
    bus.release_pulse = '0;
    if (bus.grant_valid && bus.hold_count == 3) bus.release_pulse[bus.grant_id] = 1'b1;
    bus.req = '0;
    step();
    bus.release_pulse = '0;
    step();

    // 3: stuck owner core 1, watchdog revoke, core 2 next
    do_reset();
    c = cyc;
    expect_grant(1, c + 1);
    expect_to(c + 16);
    expect_grant(2, c + 17);
    bus.req = 4'b0010;
    steps(2);
    bus.req = 4'b0100;
    steps(13);
    check("t3_hold15", bus.hold_count, 15);
    check("t3_still_owner", bus.grant, 4'b0010);
    step();
    check("t3_timeout", bus.timeout, 1);
    check("t3_revoked", bus.grant, 0);
    step();
    check("t3_next", bus.grant, 4'b0100);
    bus.release_pulse = 4'b0100;
    bus.req = '0;
    step();
    bus.release_pulse = '0;
    step();

    // 4: release on the watchdog cycle wins
    c = cyc;
    expect_grant(0, c + 1);
    expect_grant(3, c + 17);
    bus.req = 4'b0001;
    steps(15);
    check("t4_hold15", bus.hold_count, 15);
    bus.release_pulse = 4'b0001;
    bus.req = 4'b1000;
    step();
    bus.release_pulse = '0;
    check("t4_no_timeout", bus.timeout, 0);
    check("t4_turn", bus.grant, 0);
    step();
    bus.release_pulse = 4'b1000;
    bus.req = '0;
    step();
    bus.release_pulse = '0;
    step();

    // 5: non-owner release ignored, asynchronous reset mid-grant
    do_reset();
    c = cyc;
    expect_grant(0, c + 1);
    bus.req = 4'b0001;
    steps(2);
    bus.release_pulse = 4'b1000;
    step();
    bus.release_pulse = '0;
    check("t5_kept", bus.grant, 4'b0001);
    check("t5_hold3", bus.hold_count, 3);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_grant", bus.grant, 0);
    check("t5_async_valid", bus.grant_valid, 0);
    bus.req = '0;
    step();
    reset = 1'b0;
    c = cyc;
    expect_grant(0, c + 1);
    expect_grant(3, c + 3);
    bus.req = 4'b1001;
    step();
    bus.release_pulse = 4'b0001;
    bus.req = 4'b1000;
    step();
    bus.release_pulse = '0;
    check("t5_turn", bus.grant, 0);
    step();
    check("t5_second", bus.grant, 4'b1000);
    bus.release_pulse = 4'b1000;
    bus.req = '0;
    step();
    bus.release_pulse = '0;
    steps(2);
    check("sb_drain", sb.size(), 0);

    // 6: random traffic, invariant and starvation checks only
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      r = bus.req;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (bus.grant[i] && $urandom_range(3) == 0) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(7) == 0) r[i] = 1'b1;
      end
      bus.req = r;
      bus.release_pulse = '0;
      if (bus.grant_valid && $urandom_range(5) == 0) bus.release_pulse[bus.grant_id] = 1'b1;
      if ($urandom_range(7) == 0) bus.release_pulse[$urandom_range(NUM_CORES - 1)] = 1'b1;
      step();
    end
    rand_mode = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
